// File: rtl/jt6295_pkg.sv
// Shared types and constants for the JT6295 command decoder / phrase fetcher.
package jt6295_pkg;

   typedef enum logic [1:0] {
      CMD_IDLE,
      CMD_CH,
      CMD_ATT,
      CMD_STOP8
   } cmd_st_t;

   typedef enum logic [1:0] {
      F_IDLE,
      F_RD,
      F_COMMIT
   } fetch_st_t;

   // Byte offsets inside an 8-byte phrase header
   localparam logic [2:0] START_B0 = 3'd0;
   localparam logic [2:0] START_B1 = 3'd1;
   localparam logic [2:0] START_B2 = 3'd2;
   localparam logic [2:0] STOP_B0  = 3'd3;
   localparam logic [2:0] STOP_B1  = 3'd4;
   localparam logic [2:0] STOP_B2  = 3'd5;

   // Queue entry; mask is sized for the 8-channel build, the 4-channel build
   // keeps the upper nibble at zero
   typedef struct packed {
      logic [6:0] phrase;
      logic [7:0] mask;
      logic [3:0] att;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

   function automatic logic is_start_byte(input logic [2:0] b);
      return b inside {START_B0, START_B1, START_B2};
   endfunction

   function automatic logic is_stop_byte(input logic [2:0] b);
      return b inside {STOP_B0, STOP_B1, STOP_B2};
   endfunction

endpackage

// File: rtl/jt6295_cmdfifo.sv
// Synchronous command FIFO. A push on a full FIFO is accepted when a pop
// happens on the same cycle, since the popped slot is freed at that edge.
module jt6295_cmdfifo #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
)(
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;
   logic          do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == (PW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      cnt <= cnt + 1'b1;
         else if (do_pop && !do_push) cnt <= cnt - 1'b1;
      end
   end

   // Storage array, no reset needed
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/jt6295_ctrlq.sv
// JT6295 command decoder and phrase-header fetcher.
// Build option: JT6295_CTRLQ_QUEUE_EN selects a QD-deep command queue;
// without it a single holding register is used (newest start wins, ovf=0).
module jt6295_ctrlq
   import jt6295_pkg::*;
#(
   parameter int unsigned CH     = 4,
   parameter int unsigned AW     = 18,
   parameter int unsigned QD     = 4,
   parameter int unsigned RETRIG = 0
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          cen4,
   input  logic          wrn,
   input  logic [7:0]    din,
   output logic [9:0]    rom_addr,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic [AW-1:0] start_addr,
   output logic [AW-1:0] stop_addr,
   output logic [3:0]    att,
   output logic [CH-1:0] start,
   output logic [CH-1:0] stop,
   input  logic [CH-1:0] busy,
   input  logic [CH-1:0] ack,
   output logic          ovf
);

   logic       wr_l, dec_v;
   logic [7:0] din_l;

   // Register the CPU strobe; a byte is decoded the cycle after its rising edge
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_l  <= 1'b1;
         dec_v <= 1'b0;
         din_l <= '0;
      end else begin
         wr_l  <= wrn;
         dec_v <= wrn & ~wr_l;
         din_l <= din;
      end
   end

   cmd_st_t    cmd_st, cmd_nx;
   logic [6:0] phrase_q, phrase_nx;
   logic [7:0] mask_q, mask_nx, push_mask, stop_set;
   logic [3:0] push_att;
   logic       push;
   cmd_t       push_data;

   // Command decoder state
   always_ff @(posedge clk) begin
      if (!rstn) begin
         cmd_st   <= CMD_IDLE;
         phrase_q <= '0;
         mask_q   <= '0;
      end else begin
         cmd_st   <= cmd_nx;
         phrase_q <= phrase_nx;
         mask_q   <= mask_nx;
      end
   end

   // Command decoder next state, push request and stop bits to raise
   always_comb begin
      cmd_nx    = cmd_st;
      phrase_nx = phrase_q;
      mask_nx   = mask_q;
      push      = 1'b0;
      push_mask = mask_q;
      push_att  = din_l[3:0];
      stop_set  = '0;
      if (dec_v) begin
         unique case (cmd_st)
            CMD_IDLE: begin
               if (din_l[7]) begin
                  phrase_nx = din_l[6:0];
                  cmd_nx    = CMD_CH;
               end else if (CH == 8) begin
                  cmd_nx = CMD_STOP8;
               end else begin
                  stop_set = {4'b0, din_l[6:3]};
               end
            end
            CMD_CH: begin
               if (CH == 8) begin
                  mask_nx = din_l;
                  cmd_nx  = CMD_ATT;
               end else begin
                  push_mask = {4'b0, din_l[7:4]};
                  push      = 1'b1;
                  cmd_nx    = CMD_IDLE;
               end
            end
            CMD_ATT: begin
               push   = 1'b1;
               cmd_nx = CMD_IDLE;
            end
            CMD_STOP8: begin
               stop_set = din_l;
               cmd_nx   = CMD_IDLE;
            end
            default: cmd_nx = CMD_IDLE;
         endcase
      end
      push_data = {phrase_q, push_mask, push_att};
   end

   logic q_empty, pop;
   cmd_t q_head;

`ifdef JT6295_CTRLQ_QUEUE_EN
   logic q_full;

   jt6295_cmdfifo #(
      .W     (CMD_W),
      .DEPTH (QD)
   ) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .pop   (pop),
      .din   (push_data),
      .dout  (q_head),
      .full  (q_full),
      .empty (q_empty)
   );

   // Sticky overflow: a start lost to a full queue with no pop to make room
   always_ff @(posedge clk) begin
      if (!rstn)                        ovf <= 1'b0;
      else if (push && q_full && !pop)  ovf <= 1'b1;
   end
`else
   localparam int unsigned unused_qd = QD;
   logic hold_v;

   // Single holding register: a newer start replaces a pending one
   always_ff @(posedge clk) begin
      if (!rstn) begin
         hold_v <= 1'b0;
         q_head <= '0;
      end else if (push) begin
         hold_v <= 1'b1;
         q_head <= push_data;
      end else if (pop) begin
         hold_v <= 1'b0;
      end
   end

   assign q_empty = ~hold_v;
   assign ovf     = 1'b0;
`endif

   fetch_st_t   f_st, f_nx;
   logic [2:0]  byte_q;
   logic        wait_q;
   logic [23:0] sa_q, ea_q;
   logic [7:0]  f_mask;
   logic [3:0]  f_att;

   // Fetch FSM state register
   always_ff @(posedge clk) begin
      if (!rstn) f_st <= F_IDLE;
      else       f_st <= f_nx;
   end

   // Fetch FSM next state and queue pop
   always_comb begin
      f_nx = f_st;
      pop  = 1'b0;
      unique case (f_st)
         F_IDLE: begin
            if (!q_empty) begin
               pop  = 1'b1;
               f_nx = F_RD;
            end
         end
         F_RD:     if (!wait_q && rom_ok && byte_q == STOP_B2) f_nx = F_COMMIT;
         F_COMMIT: f_nx = F_IDLE;
         default:  f_nx = F_IDLE;
      endcase
   end

   // Header read: rom_ok is ignored on the cycle rom_addr changes (wait_q)
   always_ff @(posedge clk) begin
      if (!rstn) begin
         rom_addr   <= '0;
         byte_q     <= START_B0;
         wait_q     <= 1'b0;
         sa_q       <= '0;
         ea_q       <= '0;
         f_mask     <= '0;
         f_att      <= '0;
         start_addr <= '0;
         stop_addr  <= '0;
         att        <= '0;
      end else begin
         unique case (f_st)
            F_IDLE: begin
               if (pop) begin
                  rom_addr <= {q_head.phrase, START_B0};
                  byte_q   <= START_B0;
                  wait_q   <= 1'b1;
                  f_mask   <= q_head.mask;
                  f_att    <= q_head.att;
               end
            end
            F_RD: begin
               if (wait_q) begin
                  wait_q <= 1'b0;
               end else if (rom_ok) begin
                  if (is_start_byte(byte_q)) sa_q <= {sa_q[15:0], rom_data};
                  if (is_stop_byte(byte_q))  ea_q <= {ea_q[15:0], rom_data};
                  if (byte_q != STOP_B2) begin
                     byte_q        <= byte_q + 3'd1;
                     rom_addr[2:0] <= byte_q + 3'd1;
                     wait_q        <= 1'b1;
                  end
               end
            end
            F_COMMIT: begin
               start_addr <= sa_q[AW-1:0];
               stop_addr  <= ea_q[AW-1:0];
               att        <= f_att;
            end
            default: ;
         endcase
      end
   end

   logic [CH-1:0] grant, start_nx, stop_nx;

   // Start/stop request bookkeeping; commit is applied after ack so it wins
   always_comb begin
      grant    = (RETRIG != 0) ? '1 : ~busy;
      start_nx = start & ~ack;
      if (f_st == F_COMMIT) start_nx = start_nx | (f_mask[CH-1:0] & grant);
      stop_nx = stop;
      if (cen4) stop_nx = stop_nx & busy;
      stop_nx = stop_nx | stop_set[CH-1:0];
      if (push) stop_nx = stop_nx & ~push_mask[CH-1:0];
   end

   // Start/stop request registers
   always_ff @(posedge clk) begin
      if (!rstn) begin
         start <= '0;
         stop  <= '0;
      end else begin
         start <= start_nx;
         stop  <= stop_nx;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{sa_q, ea_q, f_mask, stop_set, push_mask};

endmodule

// File: tb/tb_jt6295_ctrlq.sv
// Directed bench for jt6295_ctrlq: a 4-channel and an 8-channel instance
// with a combinational header ROM model.
module tb_jt6295_ctrlq;

   logic        clk = 1'b0, rstn = 1'b0, cen4 = 1'b0;
   logic        wrn4 = 1'b1, wrn8 = 1'b1;
   logic [7:0]  din4 = '0, din8 = '0;
   logic [9:0]  rom_addr4, rom_addr8;
   logic [7:0]  rom_data4, rom_data8;
   logic        rom_ok4 = 1'b1, rom_ok8 = 1'b1;
   logic [17:0] sa4, ea4, sa8, ea8;
   logic [3:0]  att4, att8;
   logic [3:0]  start4, stop4, busy4 = '0, ack4 = '0;
   logic [7:0]  start8, stop8, busy8 = '0, ack8 = '0;
   logic        ovf4, ovf8;

   int unsigned n_cmp = 0, n_bad = 0;
   logic        mon_en = 1'b0;
   logic [17:0] seen[$];
   int          exp_p[$];

   always #5 clk = ~clk;

   // Header ROM: phrase 1 has a fixed header, others {p[3:0],0,k}
   function automatic logic [7:0] hdr(input logic [6:0] p, input logic [2:0] k);
      if (p == 7'd1) begin
         case (k)
            3'd1:    return 8'h01;
            3'd4:    return 8'h02;
            3'd5:    return 8'hFF;
            default: return 8'h00;
         endcase
      end
      return {p[3:0], 1'b0, k};
   endfunction

   function automatic logic [17:0] exp_sa(input logic [6:0] p);
      logic [23:0] v;
      v = {hdr(p, 3'd0), hdr(p, 3'd1), hdr(p, 3'd2)};
      return v[17:0];
   endfunction

   function automatic logic [17:0] exp_ea(input logic [6:0] p);
      logic [23:0] v;
      v = {hdr(p, 3'd3), hdr(p, 3'd4), hdr(p, 3'd5)};
      return v[17:0];
   endfunction

   assign rom_data4 = hdr(rom_addr4[9:3], rom_addr4[2:0]);
   assign rom_data8 = hdr(rom_addr8[9:3], rom_addr8[2:0]);

   jt6295_ctrlq #(.CH(4), .AW(18), .QD(4), .RETRIG(0)) u_dut4 (
      .clk(clk), .rstn(rstn), .cen4(cen4), .wrn(wrn4), .din(din4),
      .rom_addr(rom_addr4), .rom_data(rom_data4), .rom_ok(rom_ok4),
      .start_addr(sa4), .stop_addr(ea4), .att(att4),
      .start(start4), .stop(stop4), .busy(busy4), .ack(ack4), .ovf(ovf4)
   );

   jt6295_ctrlq #(.CH(8), .AW(18), .QD(4), .RETRIG(0)) u_dut8 (
      .clk(clk), .rstn(rstn), .cen4(cen4), .wrn(wrn8), .din(din8),
      .rom_addr(rom_addr8), .rom_data(rom_data8), .rom_ok(rom_ok8),
      .start_addr(sa8), .stop_addr(ea8), .att(att8),
      .start(start8), .stop(stop8), .busy(busy8), .ack(ack8), .ovf(ovf8)
   );

   // Record start_addr on every commit of the 4-channel instance
   always @(negedge clk) begin
      if (mon_en && start4 != '0) seen.push_back(sa4);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input bit to8, input logic [7:0] b);
      @(negedge clk);
      if (to8) begin din8 = b; wrn8 = 1'b0; end
      else     begin din4 = b; wrn4 = 1'b0; end
      @(negedge clk);
      if (to8) wrn8 = 1'b1;
      else     wrn4 = 1'b1;
      @(negedge clk);
   endtask

   // Wait for the phrase-1 fetch to start, then count cycles to start
   task automatic lat_phrase1(input string tag);
      int n;
      n = 0;
      while (rom_addr4 != 10'h008 && n < 20) begin @(negedge clk); n++; end
      chk({tag, "_addr_b0"}, rom_addr4, 10'h008);
      n = 0;
      while (start4 == '0 && n < 40) begin @(negedge clk); n++; end
      chk({tag, "_latency"}, n, 13);
   endtask

   initial begin
      int n;
      cyc(3);
      rstn = 1'b1;
      cyc(1);
      chk("rst_start4", start4, 4'h0);
      chk("rst_stop4",  stop4, 4'h0);
      chk("rst_ovf4",   ovf4, 1'b0);
      chk("rst_att4",   att4, 4'h0);
      chk("rst_sa4",    sa4, 18'h0);
      chk("rst_ea4",    ea4, 18'h0);
      chk("rst_rom4",   rom_addr4, 10'h0);
      chk("rst_start8", start8, 8'h0);

      // Basic start on CH=4
      wr(0, 8'h81);
      wr(0, 8'h2A);
      lat_phrase1("t1");
      chk("t1_start", start4, 4'b0010);
      chk("t1_sa",    sa4, 18'h00100);
      chk("t1_ea",    ea4, 18'h002FF);
      chk("t1_att",   att4, 4'hA);
      cyc(5);
      chk("t1_hold", start4, 4'b0010);
      ack4 = 4'b0010;
      @(negedge clk);
      ack4 = '0;
      chk("t1_ackclr", start4, 4'b0000);

      // Stop command and release on cen4
      busy4 = 4'b0101;
      wr(0, 8'h28);
      cyc(2);
      chk("t2_stop", stop4, 4'b0101);
      busy4 = '0;
      cyc(2);
      chk("t2_nocen", stop4, 4'b0101);
      cen4 = 1'b1;
      @(negedge clk);
      cen4 = 1'b0;
      chk("t2_rel", stop4, 4'b0000);

      // Start clears stop on push; busy channel dropped with RETRIG=0
      busy4 = 4'b0111;
      wr(0, 8'h38);
      cyc(2);
      chk("t2b_stop", stop4, 4'b0111);
      wr(0, 8'h82);
      wr(0, 8'h15);
      @(negedge clk);
      chk("t2b_stopclr", stop4, 4'b0110);
      n = 0;
      while (att4 != 4'h5 && n < 40) begin @(negedge clk); n++; end
      chk("t2b_att",   att4, 4'h5);
      chk("t2b_sa",    sa4, exp_sa(7'd2));
      chk("t2b_drop",  start4, 4'b0000);
      busy4 = '0;
      cen4  = 1'b1;
      @(negedge clk);
      cen4 = 1'b0;
      chk("t2b_rel", stop4, 4'b0000);

      // CH=8 start with a busy channel
      busy8 = 8'h01;
      wr(1, 8'h85);
      wr(1, 8'h03);
      wr(1, 8'h07);
      n = 0;
      while (start8 == '0 && n < 40) begin @(negedge clk); n++; end
      chk("t3_start", start8, 8'h02);
      chk("t3_att",   att8, 4'h7);
      chk("t3_sa",    sa8, exp_sa(7'd5));
      chk("t3_ea",    ea8, exp_ea(7'd5));
      ack8 = 8'h02;
      @(negedge clk);
      ack8 = '0;
      chk("t3_ackclr", start8, 8'h00);
      busy8 = 8'hC0;
      wr(1, 8'h00);
      wr(1, 8'hC0);
      cyc(2);
      chk("t3_stop8", stop8, 8'hC0);
      busy8 = '0;
      cen4  = 1'b1;
      @(negedge clk);
      cen4 = 1'b0;
      chk("t3_rel8", stop8, 8'h00);

      // Queueing behaviour while one fetch is stalled on rom_ok=0
      ack4    = '1;
      rom_ok4 = 1'b0;
      seen.delete();
      mon_en  = 1'b1;
      wr(0, 8'h83);
      wr(0, 8'h1F);
      cyc(4);
      exp_p.push_back(3);
`ifdef JT6295_CTRLQ_QUEUE_EN
      for (int p = 8; p <= 12; p++) begin
         wr(0, 8'h80 | 8'(p));
         wr(0, 8'h1F);
      end
      chk("q_ovf", ovf4, 1'b1);
      for (int p = 8; p <= 11; p++) exp_p.push_back(p);
      rom_ok4 = 1'b1;
      cyc(120);
      chk("q_ovf_sticky", ovf4, 1'b1);
`else
      wr(0, 8'h84);
      wr(0, 8'h1F);
      wr(0, 8'h86);
      wr(0, 8'h1F);
      chk("h_ovf", ovf4, 1'b0);
      exp_p.push_back(6);
      rom_ok4 = 1'b1;
      cyc(80);
`endif
      mon_en = 1'b0;
      chk("q_ncommit", seen.size(), exp_p.size());
      for (int i = 0; i < exp_p.size(); i++) begin
         if (i < seen.size()) chk($sformatf("q_commit%0d", i), seen[i], exp_sa(7'(exp_p[i])));
      end
      ack4 = '0;

      // Reset in the middle of a header read
      wr(0, 8'h87);
      wr(0, 8'h2C);
      n = 0;
      while (rom_addr4 != 10'h03B && n < 40) begin @(negedge clk); n++; end
      chk("t6_reached_b3", rom_addr4, 10'h03B);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("t6_rom",   rom_addr4, 10'h0);
      chk("t6_sa",    sa4, 18'h0);
      chk("t6_ea",    ea4, 18'h0);
      chk("t6_att",   att4, 4'h0);
      chk("t6_start", start4, 4'h0);
      chk("t6_ovf",   ovf4, 1'b0);
      cyc(20);
      chk("t6_abandon", start4, 4'h0);
      chk("t6_rom_idle", rom_addr4, 10'h0);
      wr(0, 8'h81);
      wr(0, 8'h2A);
      lat_phrase1("t6");
      chk("t6_sa2", sa4, 18'h00100);
      chk("t6_ea2", ea4, 18'h002FF);
      chk("t6_att2", att4, 4'hA);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/jt6295_ctrlq.md
# jt6295_ctrlq

Parametrised command decoder and phrase-table fetcher for the JT6295 ADPCM core. It sits between the CPU write port and the channel engines. It decodes start and stop commands for 4 or 8 channels and queues pending starts. It reads each phrase's start/stop addresses from the ROM header, then hands the addresses, attenuation and a per-channel start mask to the channel engines. Compared with the original controller it adds a command queue, 8-channel support, configurable sample-address width and a busy-channel retrigger policy.

## Interface
Parameters:
- CH, 4 — channel count; only 4 or 8 is legal.
- AW, 18 — sample address width, 16..24.
- QD, 4 — command queue depth, power of 2, 2..16.
- RETRIG, 0 — 1: a start on a busy channel is honoured; 0: that channel's bit is dropped.

Ports:
- clk  in  1  — system clock.
- rstn  in  1  — synchronous, active-low reset.
- cen4  in  1  — clock enable used for busy/stop sampling.
- wrn  in  1  — CPU write strobe; a command byte is taken on its rising edge.
- din  in  8  — CPU write data.
- rom_addr  out  10  — phrase header address, {phrase[6:0], byte[2:0]}.
- rom_data  in  8  — header byte.
- rom_ok  in  1  — rom_data is valid for the current rom_addr.
- start_addr  out  AW  — phrase start address.
- stop_addr  out  AW  — phrase stop address.
- att  out  4  — attenuation.
- start  out  CH  — per-channel start request, held until acknowledged.
- stop  out  CH  — per-channel stop request.
- busy  in  CH  — channel playing.
- ack  in  CH  — channel accepted its start request.
- ovf  out  1  — sticky flag: a start command was lost because the queue was full.

## Operation
- Command byte decoder, states CMD_IDLE, CMD_CH, CMD_ATT, CMD_STOP8.
  - CMD_IDLE, din[7]=1: latch phrase=din[6:0], go to CMD_CH.
  - CMD_IDLE, din[7]=0:
    - CH=4: stop |= din[6:3].
    - CH=8: go to CMD_STOP8.
  - CMD_CH, CH=4: mask=din[7:4], att=din[3:0], push, go to CMD_IDLE.
  - CMD_CH, CH=8: mask=din[7:0], go to CMD_ATT.
  - CMD_ATT: att=din[3:0], push, go to CMD_IDLE.
  - CMD_STOP8: stop |= din[7:0], go to CMD_IDLE.
- Push writes {phrase, mask, att} into the queue.
  - Queue full: drop the command, set ovf.
  - A push with mask=0 is still fetched but asserts no start bits.
- Stop release: on cen4, stop[i] clears when busy[i]=0.
- A start command whose mask includes channel i clears stop[i] the same cycle it is pushed.
- Fetch FSM, states F_IDLE, F_RD(0..5), F_COMMIT.
  - F_IDLE with queue non-empty: pop the head and enter F_RD(0).
  - F_RD(k): drive byte=k and wait for rom_ok, then capture rom_data.
  - Bytes 0..2 form start address {b0,b1,b2}; bytes 3..5 form stop address {b3,b4,b5}.
  - Each 24-bit value is truncated to its AW LSBs.
  - F_COMMIT: update start_addr, stop_addr and att; then apply start |= mask & (RETRIG ? all-ones : ~busy); return to F_IDLE.
- Start release: start[i] clears when ack[i]=1 on any cycle, not gated by cen4.
- If a commit and an ack for the same bit land on the same cycle, the commit wins.
- Reset:
  - start, stop, ovf, att, start_addr, stop_addr, rom_addr all 0.
  - Queue empty; both FSMs idle.
  - Reset asserted mid-fetch abandons the fetch.

## Timing
- wrn is registered once, so a command byte is decoded 1 cycle after the wrn rising edge.
- Push happens on the decode cycle of the last byte of a start command.
- Pop can occur on the cycle after a push, i.e. the queue has 1 cycle of fall-through latency.
- ROM read:
  - rom_addr is stable from the cycle it is driven until rom_ok is seen.
  - rom_ok must be sampled no earlier than 1 cycle after rom_addr changes (same rule as the existing SDRAM slot).
- With rom_ok held at 1, each byte takes 2 cycles, so pop-to-start is 13 cycles.
- start_addr, stop_addr and att hold their values until the next commit.
- Simultaneous push and pop on a full queue is allowed and does not set ovf.

## Configuration
- JT6295_CTRLQ_QUEUE_EN defined: queue depth is QD.
- Undefined: single holding register. A new start command overwrites a pending, not-yet-popped command and ovf is tied to 0. This matches legacy MSM6295 behaviour.

## Structure
- Package jt6295_pkg holds:
  - command FSM and fetch FSM state enums;
  - header byte offsets (START_B0=0 .. STOP_B2=5);
  - the queue entry record type {phrase, mask, att}.
- Sub-module jt6295_cmdfifo: a parametrised synchronous FIFO with full, empty and a push-while-full-and-pop bypass.

## Test plan
- CH=4, rom_ok=1, header bytes 00 01 00 00 02 FF, write 0x81 then 0x2A → start=4'b0010 13 cycles after pop; start_addr=0x00100; stop_addr=0x002FF; att=0xA.
- CH=4, write 0x28 with busy=4'b0101, then drop busy on a cen4 → stop=4'b0101, then cleared.
- CH=8, RETRIG=0, busy=8'h01, write 0x85, 0x03, 0x07 → start=8'h02, att=7.
- With JT6295_CTRLQ_QUEUE_EN, QD=4, rom_ok=0, push 5 starts → ovf=1; after releasing rom_ok, exactly 4 commits occur, in order.
- Without the macro, push 2 starts while rom_ok=0 → only the second phrase is fetched.
- Deassert rstn mid-fetch at F_RD(3) → all outputs return to 0; the next command fetches from byte 0.
